// File: rtl/lock_ctrl_pkg.sv
// Shared types and default widths for the key-sweep (SAT-free brute force) lock controller.
package lock_ctrl_pkg;

   localparam int IN_W_DEF  = 5;
   localparam int KEY_W_DEF = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_DONE  = 2'd2
   } sweep_state_t;

endpackage

// File: rtl/key_sweep_ctrl.sv
// Walks every candidate key against every input pattern through an external miter,
// rejecting a key on its first mismatching pattern and reporting the first fully matching key.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; results and pat_o/key_o hold
// ST_SWEEP | pattern/key presented to the miter, eq_i judged each cycle
// ST_DONE  | one-cycle completion pulse, then back to ST_IDLE
module key_sweep_ctrl
   import lock_ctrl_pkg::*;
#(
   parameter int IN_W  = IN_W_DEF,
   parameter int KEY_W = KEY_W_DEF
) (
   input  logic             C,
   input  logic             R,
   input  logic             start,
   input  logic             abort,
   input  logic             eq_i,
   output logic [IN_W-1:0]  pat_o,
   output logic [KEY_W-1:0] key_o,
   output logic             busy,
   output logic             done,
   output logic             found,
   output logic [KEY_W-1:0] key_found,
   output logic [KEY_W:0]   rej_cnt,
   output logic [IN_W-1:0]  fail_pat
);

   localparam logic [IN_W-1:0]  PAT_MAX = '1;
   localparam logic [KEY_W-1:0] KEY_MAX = '1;
   localparam logic [KEY_W:0]   REJ_MAX = {1'b1, {KEY_W{1'b0}}};

   sweep_state_t     state, state_nxt;
   logic [IN_W-1:0]  pat_nxt, fail_pat_nxt;
   logic [KEY_W-1:0] key_nxt, key_found_nxt;
   logic [KEY_W:0]   rej_cnt_nxt;
   logic             found_nxt;

   always_ff @(posedge C) begin
      if (R) begin
         state     <= ST_IDLE;
         pat_o     <= '0;
         key_o     <= '0;
         found     <= 1'b0;
         key_found <= '0;
         rej_cnt   <= '0;
         fail_pat  <= '0;
      end else begin
         state     <= state_nxt;
         pat_o     <= pat_nxt;
         key_o     <= key_nxt;
         found     <= found_nxt;
         key_found <= key_found_nxt;
         rej_cnt   <= rej_cnt_nxt;
         fail_pat  <= fail_pat_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      pat_nxt       = pat_o;
      key_nxt       = key_o;
      found_nxt     = found;
      key_found_nxt = key_found;
      rej_cnt_nxt   = rej_cnt;
      fail_pat_nxt  = fail_pat;

      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt     = ST_SWEEP;
               pat_nxt       = '0;
               key_nxt       = '0;
               found_nxt     = 1'b0;
               key_found_nxt = '0;
               rej_cnt_nxt   = '0;
               fail_pat_nxt  = '0;
            end
         end
         ST_SWEEP: begin
            // abort wins over both a final match and key exhaustion
            if (abort) begin
               state_nxt = ST_IDLE;
               found_nxt = 1'b0;
            end else if (eq_i) begin
               if (pat_o == PAT_MAX) begin
                  found_nxt     = 1'b1;
                  key_found_nxt = key_o;
                  state_nxt     = ST_DONE;
               end else begin
                  pat_nxt = pat_o + 1'b1;
               end
            end else begin
               if (rej_cnt != REJ_MAX) rej_cnt_nxt = rej_cnt + 1'b1;
               fail_pat_nxt = pat_o;
               if (key_o == KEY_MAX) begin
                  state_nxt = ST_DONE;
               end else begin
                  key_nxt = key_o + 1'b1;
                  pat_nxt = '0;
               end
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign busy = (state == ST_SWEEP);
   assign done = (state == ST_DONE);

endmodule

// File: tb/tb_key_sweep_ctrl.sv
// Bench for key_sweep_ctrl: a trace model derived from the sweep rules predicts every cycle's outputs.
module tb_key_sweep_ctrl;

   localparam int IN_W  = 3;
   localparam int KEY_W = 2;
   localparam int PMAX  = (1 << IN_W) - 1;
   localparam int KMAX  = (1 << KEY_W) - 1;

   logic             C = 1'b0;
   logic             R = 1'b1;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic             eq_i;
   logic [IN_W-1:0]  pat_o, fail_pat;
   logic [KEY_W-1:0] key_o, key_found;
   logic [KEY_W:0]   rej_cnt;
   logic             busy, done, found;

   int stub_mode = 0;
   int tests = 0;
   int fails = 0;
   int busy_cnt = 0;
   int done_cnt = 0;
   int model_len = 0;

   typedef struct {
      bit busy; bit done; int pat; int key;
      bit found; int kf; int rej; int fp;
   } snap_t;

   snap_t exp_q[$];

   key_sweep_ctrl #(.IN_W(IN_W), .KEY_W(KEY_W)) dut (
      .C(C), .R(R), .start(start), .abort(abort), .eq_i(eq_i),
      .pat_o(pat_o), .key_o(key_o), .busy(busy), .done(done),
      .found(found), .key_found(key_found), .rej_cnt(rej_cnt), .fail_pat(fail_pat)
   );

   always #5 C = ~C;

   // miter stub: 0 -> only key 2 matches, 1 -> never matches, 2 -> all match except key 0 at pattern 5
   function automatic bit stub_eq(int mode, int p, int k);
      case (mode)
         0:       return (k == 2);
         1:       return 1'b0;
         default: return !(k == 0 && p == 5);
      endcase
   endfunction

   always_comb eq_i = stub_eq(stub_mode, int'(pat_o), int'(key_o));

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp_v);
      tests++;
      if (act !== exp_v) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp_v);
      end
   endfunction

   function automatic void push(bit b, bit d, int p, int k, bit f, int kf, int r, int fp);
      snap_t s;
      s.busy = b; s.done = d; s.pat = p; s.key = k;
      s.found = f; s.kf = kf; s.rej = r; s.fp = fp;
      exp_q.push_back(s);
   endfunction

   // Expected outputs for every cycle after the accepted start, from the brute-force search order.
   function automatic void build(int mode, int abort_at, int reset_at, int n_sweeps);
      int cyc, rej, fp, kf, lp, lk;
      bit fnd, ended;
      for (int s = 0; s < n_sweeps; s++) begin
         cyc = 0; rej = 0; fp = 0; kf = 0; lp = 0; lk = 0; fnd = 0; ended = 0;
         for (int k = 0; k <= KMAX && !ended; k++) begin
            for (int p = 0; p <= PMAX; p++) begin
               cyc++;
               push(1, 0, p, k, 0, 0, rej, fp);
               lp = p; lk = k;
               if (cyc == abort_at) begin
                  push(0, 0, p, k, 0, 0, rej, fp);
                  return;
               end
               if (cyc == reset_at) begin
                  push(0, 0, 0, 0, 0, 0, 0, 0);
                  return;
               end
               if (!stub_eq(mode, p, k)) begin
                  rej++; fp = p;
                  break;
               end
               if (p == PMAX) begin
                  fnd = 1; kf = k; ended = 1;
               end
            end
         end
         push(0, 1, lp, lk, fnd, kf, rej, fp);
         push(0, 0, lp, lk, fnd, kf, rej, fp);
      end
   endfunction

   always @(negedge C) begin
      snap_t s;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_cnt++;
      if (exp_q.size() != 0) begin
         s = exp_q.pop_front();
         chk("busy",      32'(busy),      32'(s.busy));
         chk("done",      32'(done),      32'(s.done));
         chk("pat_o",     32'(pat_o),     s.pat);
         chk("key_o",     32'(key_o),     s.key);
         chk("found",     32'(found),     32'(s.found));
         chk("key_found", 32'(key_found), s.kf);
         chk("rej_cnt",   32'(rej_cnt),   s.rej);
         chk("fail_pat",  32'(fail_pat),  s.fp);
      end
   end

   task automatic wait_drain(int limit);
      for (int i = 0; i < limit && exp_q.size() != 0; i++) @(posedge C);
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
   endtask

   // start rises in cycle 0; start_len cycles later it drops (1 = single pulse)
   task automatic run(int mode, int abort_at, int reset_at, int n_sweeps, int start_len);
      stub_mode = mode;
      @(posedge C); #1;
      start = 1'b1; busy_cnt = 0; done_cnt = 0;
      @(negedge C); #1;
      build(mode, abort_at, reset_at, n_sweeps);
      model_len = exp_q.size();
      repeat (start_len) @(posedge C);
      #1 start = 1'b0;
      if (abort_at > 0) begin
         repeat (abort_at - 1) @(posedge C);
         #1 abort = 1'b1;
         @(posedge C); #1 abort = 1'b0;
      end
      if (reset_at > 0) begin
         repeat (reset_at - 1) @(posedge C);
         #1 R = 1'b1;
         @(posedge C); #1 R = 1'b0;
      end
      wait_drain(200);
      @(posedge C); #1;
   endtask

   task automatic check_result(string tag, int f, int kf, int rej, int fp, int bcyc, int dcnt);
      chk({tag, "_found"},  32'(found),     f);
      chk({tag, "_keyfnd"}, 32'(key_found), kf);
      chk({tag, "_rej"},    32'(rej_cnt),   rej);
      chk({tag, "_failpat"},32'(fail_pat),  fp);
      chk({tag, "_busycyc"},busy_cnt,       bcyc);
      chk({tag, "_donecnt"},done_cnt,       dcnt);
   endtask

   initial begin
      repeat (2) @(posedge C);
      @(negedge C);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_pat",  32'(pat_o), 0);
      chk("rst_key",  32'(key_o), 0);
      chk("rst_found",32'(found), 0);
      chk("rst_kf",   32'(key_found), 0);
      chk("rst_rej",  32'(rej_cnt), 0);
      chk("rst_fp",   32'(fail_pat), 0);
      @(posedge C); #1 R = 1'b0;

      // key 2 is the only match: 10 sweep cycles, done in cycle 11
      run(0, 0, 0, 1, 1);
      chk("s1_model_len", model_len, 12);
      check_result("s1", 1, 2, 2, 0, 10, 1);

      // nothing ever matches
      run(1, 0, 0, 1, 1);
      chk("s2_model_len", model_len, 6);
      check_result("s2", 0, 0, 4, 0, 4, 1);

      // key 0 fails at pattern 5 only
      run(2, 0, 0, 1, 1);
      chk("s3_model_len", model_len, 16);
      check_result("s3", 1, 1, 1, 5, 14, 1);

      // abort in IDLE must leave results untouched
      #1 abort = 1'b1;
      @(posedge C); #1 abort = 1'b0;
      @(negedge C);
      chk("idle_abort_busy",  32'(busy), 0);
      chk("idle_abort_found", 32'(found), 1);
      chk("idle_abort_kf",    32'(key_found), 1);
      @(posedge C); #1;

      // abort coincides with the final matching pattern
      run(0, 10, 0, 1, 1);
      check_result("abort", 0, 0, 2, 0, 10, 0);
      chk("abort_pat", 32'(pat_o), 7);

      // synchronous reset mid-sweep, then an identical re-run
      run(0, 0, 4, 1, 1);
      check_result("rst_mid", 0, 0, 0, 0, 4, 0);
      chk("rst_mid_pat", 32'(pat_o), 0);
      chk("rst_mid_key", 32'(key_o), 0);
      run(0, 0, 0, 1, 1);
      check_result("rerun", 1, 2, 2, 0, 10, 1);

      // start held through busy and DONE: one sweep per IDLE visit
      run(0, 0, 0, 2, 14);
      chk("held_model_len", model_len, 24);
      check_result("held", 1, 2, 2, 0, 20, 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout, want finish");
      $fatal(1, "timeout");
   end

endmodule
